// File: rtl/cdc_handshake_tx.sv
// Source-side transmitter of a four-phase req/ack synchronizer: captures a local word,
// holds it on tx_data and runs one full req/ack handshake with the destination domain.
module cdc_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  input  logic              tx_ack,
  output logic              busy,
  output logic [15:0]       xfer_cnt,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [CNT_W-1:0]       phase_cnt;
  logic                   accept;
  logic                   done;
  logic                   moved;
  logic                   err_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // ack synchronizer: only the last stage feeds logic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_sync <= '0;
    else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], tx_ack};
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign in_ready = (state == IDLE) && !ack_s;
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        state_next = REQ;
        accept     = 1'b1;
      end
      REQ:  if (ack_s) state_next = DROP;
      DROP: if (!ack_s) begin
        state_next = IDLE;
        done       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign moved = (state_next != state);
  // Fires on the edge where the phase count becomes TIMEOUT_CYC-1; saturation keeps it one-shot.
  assign err_set = busy && !moved && (phase_cnt == CNT_PRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      xfer_cnt    <= '0;
      timeout_err <= 1'b0;
      phase_cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        tx_req  <= 1'b1;
        tx_data <= in_data;
      end else if ((state == REQ) && ack_s) begin
        tx_req <= 1'b0;
      end
      if (done) xfer_cnt <= xfer_cnt + 16'd1;
      if (moved)     phase_cnt <= '0;
      else if (busy) phase_cnt <= sat_inc(phase_cnt);
      if (err_set)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: vector table, hand-built corner sequences,
// and randomized transfers against a delivery/latency model with a random-delay responder.
`timescale 1ns/1ps
module tb_cdc_handshake_tx;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_req;
  logic              tx_ack;
  logic              busy;
  logic [15:0]       xfer_cnt;
  logic              timeout_err;
  logic              err_clr = 1'b0;

  logic man_ack  = 1'b0;
  logic auto_en  = 1'b0;
  logic resp_ack = 1'b0;
  logic mon_en   = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdly = -1;
  int max_dly = 0;
  int t_rise = 0;
  int t_fall = 0;
  logic [15:0] exp_cnt = '0;
  logic [7:0]  got[$];

  assign tx_ack = auto_en ? resp_ack : man_ack;

  cdc_handshake_tx #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack),
    .busy(busy), .xfer_cnt(xfer_cnt), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Destination-side responder: mirrors tx_req onto ack after a random number of cycles.
  always @(negedge clk) begin
    if (!auto_en) begin
      resp_ack = 1'b0;
      rdly = -1;
    end else if (resp_ack != tx_req) begin
      if (rdly < 0) rdly = int'($urandom_range(max_dly, 0));
      if (rdly == 0) begin
        resp_ack = tx_req;
        rdly = -1;
        if (tx_req) t_rise = cyc;
        else        t_fall = cyc;
      end else begin
        rdly--;
      end
    end
  end

  // Protocol monitor: word stability, delivery order and ack-to-effect latency.
  logic       prev_busy = 1'b0;
  logic       prev_req = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_busy && busy) chk("tx_data_stable", tx_data, prev_data);
      if (in_ready) chk("ready_while_busy", busy, 0);
      if (!prev_req && tx_req) got.push_back(tx_data);
      if (prev_req && !tx_req) chk("req_drop_latency", cyc - t_rise, SYNC_STAGES + 1);
      if (prev_busy && !busy) chk("idle_latency", cyc - t_fall, SYNC_STAGES + 1);
    end
    prev_busy = busy;
    prev_req  = tx_req;
    prev_data = tx_data;
  end

  task automatic send_words(input int n, input int gap_max, input int dly_max,
                            input bit seq, input string tag);
    logic [7:0] sent[$];
    int idx;
    int budget;
    logic rdy;
    logic v;
    sent.delete();
    got.delete();
    for (int i = 0; i < n; i++) sent.push_back(seq ? 8'(i + 1) : 8'($urandom));
    max_dly = dly_max;
    auto_en = 1'b1;
    mon_en  = 1'b1;
    idx = 0;
    budget = n * 40 + 100;
    in_valid = 1'b0;
    while (idx < n && budget > 0) begin
      if (!in_valid) begin
        if ($urandom_range(gap_max, 0) == 0) begin
          in_valid = 1'b1;
          in_data  = sent[idx];
        end else begin
          in_data = 8'($urandom);
        end
      end
      rdy = in_ready;
      v   = in_valid;
      step();
      budget--;
      if (v && rdy) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    while ((busy || tx_ack) && budget > 0) begin
      step();
      budget--;
    end
    chk({tag, "_budget"}, budget > 0, 1);
    mon_en  = 1'b0;
    auto_en = 1'b0;
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_word"}, got[i], sent[i]);
    exp_cnt = exp_cnt + 16'(n);
    chk({tag, "_xfer_cnt"}, xfer_cnt, exp_cnt);
    chk({tag, "_timeout"}, timeout_err, 0);
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       ack;
    logic       rdy;
    logic       req;
    logic       bsy;
    logic [7:0] txd;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mkv(logic v, logic [7:0] d, logic a, logic r, logic q,
                               logic b, logic [7:0] t, logic [15:0] c);
    vec_t x;
    x.vld = v; x.d = d; x.ack = a; x.rdy = r; x.req = q; x.bsy = b; x.txd = t; x.cnt = c;
    return x;
  endfunction

  vec_t tbl[10];

  initial begin
    // single 0xA5 transfer: ack raised after 3 cycles, dropped 3 cycles later
    tbl[0] = mkv(1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0);
    tbl[1] = mkv(0, 8'h3C, 0, 0, 1, 1, 8'hA5, 0);
    tbl[2] = mkv(0, 8'hC3, 0, 0, 1, 1, 8'hA5, 0);
    tbl[3] = mkv(0, 8'h00, 1, 0, 1, 1, 8'hA5, 0);
    tbl[4] = mkv(1, 8'h5A, 1, 0, 1, 1, 8'hA5, 0);
    tbl[5] = mkv(0, 8'hFF, 1, 0, 0, 1, 8'hA5, 0);
    tbl[6] = mkv(1, 8'h66, 0, 0, 0, 1, 8'hA5, 0);
    tbl[7] = mkv(0, 8'h99, 0, 0, 0, 1, 8'hA5, 0);
    tbl[8] = mkv(0, 8'h12, 0, 1, 0, 0, 8'hA5, 1);
    tbl[9] = mkv(0, 8'h34, 0, 1, 0, 0, 8'hA5, 1);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_req", tx_req, 0);
    rst = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_tx_req", tx_req, 0);
    chk("rel_tx_data", tx_data, 0);
    chk("rel_busy", busy, 0);
    chk("rel_xfer_cnt", xfer_cnt, 0);
    chk("rel_timeout", timeout_err, 0);

    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].d;
      man_ack  = tbl[i].ack;
      step();
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_tx_req", i), tx_req, tbl[i].req);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].txd);
      chk($sformatf("vec%0d_xfer_cnt", i), xfer_cnt, tbl[i].cnt);
    end
    in_valid = 1'b0;
    man_ack  = 1'b0;
    exp_cnt  = 16'd1;

    // back-to-back 0x01..0x04 with instant responder
    send_words(4, 0, 0, 1'b1, "b2b");

    // ack withheld: timeout, clear, then set-wins-over-clear in DROP
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("to_req", tx_req, 1);
    step(14);
    chk("to_err_early", timeout_err, 0);
    step();
    chk("to_err_set", timeout_err, 1);
    chk("to_req_held", tx_req, 1);
    step(5);
    chk("to_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", timeout_err, 0);
    step(3);
    chk("to_err_no_reset", timeout_err, 0);
    man_ack = 1'b1;
    step(3);
    chk("to_drop_req", tx_req, 0);
    chk("to_drop_busy", busy, 1);
    step(14);
    chk("to_drop_err_early", timeout_err, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_set_wins", timeout_err, 1);
    man_ack = 1'b0;
    step(2);
    chk("to_still_busy", busy, 1);
    step();
    chk("to_done_busy", busy, 0);
    chk("to_done_ready", in_ready, 1);
    exp_cnt = exp_cnt + 16'd1;
    chk("to_xfer_cnt", xfer_cnt, exp_cnt);
    chk("to_tx_data", tx_data, 8'h3C);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_final_clr", timeout_err, 0);

    // asynchronous reset in REQ with ack held high
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    in_valid = 1'b0;
    man_ack  = 1'b1;
    step();
    chk("mr_req_before", tx_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_req_async", tx_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_tx_data", tx_data, 0);
    chk("mr_xfer_cnt", xfer_cnt, 0);
    exp_cnt = '0;
    @(negedge clk);
    step();
    rst = 1'b1;
    step(SYNC_STAGES);
    chk("mr_ready_blocked0", in_ready, 0);
    step(3);
    chk("mr_ready_blocked1", in_ready, 0);
    man_ack = 1'b0;
    step(SYNC_STAGES - 1);
    chk("mr_ready_blocked2", in_ready, 0);
    step();
    chk("mr_ready_open", in_ready, 1);
    chk("mr_req_idle", tx_req, 0);

    // randomized traffic against the delivery model
    send_words(30, 3, 5, 1'b0, "rand");

    // counter wrap from a preloaded 0xFFFF
    @(negedge clk);
    force dut.xfer_cnt = 16'hFFFF;
    #1;
    release dut.xfer_cnt;
    chk("wrap_preload", xfer_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    send_words(1, 0, 0, 1'b0, "wrap");
    chk("wrap_zero", xfer_cnt, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side transmitter of a four-phase req/ack bus synchronizer. It runs entirely in the sending clock domain. It captures a multi-bit word from a local valid/ready interface and holds it stable on `tx_data` for the whole handshake. It drives `tx_req` and synchronizes the asynchronous `tx_ack` returned by the destination-domain receiver. It is the counterpart of the receiver that samples `tx_data` only after seeing synchronized `tx_req`, and it replaces raw multi-bit flop-to-flop crossings between the fast and slow domains.

## Interface
- `DATA_W`, 8, width of the transferred word
- `SYNC_STAGES`, 2, flop stages on `tx_ack` (legal values 2..4)
- `TIMEOUT_CYC`, 1024, cycles spent in one handshake phase before `timeout_err` sets (≥2)
- `clk`  input  1  single clock; all logic on posedge
- `rst`  input  1  reset, asynchronous assert, active-low (0 = reset)
- `in_valid`  input  1  local word available
- `in_data`  input  DATA_W  local word
- `in_ready`  output  1  block can accept a word this cycle
- `tx_data`  output  DATA_W  registered word, stable while `tx_req`=1 and until `tx_ack` synchronizes low
- `tx_req`  output  1  registered request to destination domain
- `tx_ack`  input  1  asynchronous acknowledge from destination domain
- `busy`  output  1  handshake in progress (state ≠ IDLE)
- `xfer_cnt`  output  16  completed transfers, wraps 0xFFFF→0x0000
- `timeout_err`  output  1  sticky: a phase exceeded TIMEOUT_CYC
- `err_clr`  input  1  synchronous clear of `timeout_err`

## Operation
- `ack_s`: `tx_ack` passed through SYNC_STAGES flops. Only the last stage is used by logic.
- FSM states: IDLE, REQ, DROP.
  - IDLE → REQ when `in_valid`=1 and `in_ready`=1. `tx_data` <= `in_data` on the same edge.
  - REQ → DROP when `ack_s`=1.
  - DROP → IDLE when `ack_s`=0. `xfer_cnt` increments on that same edge.
- Outputs by state:
  - `tx_req` is a flop set on entry to REQ and cleared on entry to DROP. It is never combinational from state.
  - `in_ready` = (state==IDLE) && (`ack_s`==0). This blocks a new transfer while a stale ack from a prior or interrupted handshake is still high.
  - `busy` = (state≠IDLE).
  - `tx_data` changes only on the IDLE→REQ edge. It is never altered in REQ or DROP.
- Timeout:
  - A phase counter clears on every state transition. It increments each cycle in REQ or DROP and saturates.
  - When the count reaches TIMEOUT_CYC−1, `timeout_err` sets. The FSM keeps waiting; there is no abort.
  - `err_clr`=1 clears `timeout_err`. If set and clear coincide, set wins.
- Reset (asynchronous, mid-operation allowed):
  - State → IDLE, `tx_req`=0, `tx_data`=0, sync flops=0, `xfer_cnt`=0, `timeout_err`=0, phase counter=0.
  - After release, `in_ready`=1 only once `ack_s` reads 0.

## Timing
- Reset values: `in_ready`=1 (sync flops are 0), `tx_req`=0, `tx_data`=0, `busy`=0, `xfer_cnt`=0, `timeout_err`=0.
- Accept on edge N → `tx_req`=1 and `tx_data` valid after edge N. `in_ready`=0 from edge N.
- `tx_ack` rises before edge M → `ack_s`=1 after edge M+SYNC_STAGES−1. `tx_req`=0 after the following edge.
- `tx_ack` falls → the same SYNC_STAGES latency applies, then IDLE and `xfer_cnt`+1 on one edge. `in_ready`=1 in the next cycle.
- Minimum handshake with instant ack: 2·SYNC_STAGES+2 cycles per word, i.e. 6 at the default.
- `in_valid` held high continuously: back-to-back words are accepted, one per completed handshake. No word is lost or duplicated.

## Test plan
- Reset with `rst`=0, then release: all outputs at reset values. `in_ready`=1 with `tx_ack`=0.
- Single transfer `in_data`=0xA5, model ack after 3 cycles, release 3 cycles later: `tx_data`=0xA5 throughout, `tx_req` 1→0 exactly SYNC_STAGES+1 cycles after ack rise, `xfer_cnt`=1.
- Four back-to-back words 0x01, 0x02, 0x03, 0x04 with instant-ack responder: order preserved, each `tx_data` stable while `tx_req`=1, `xfer_cnt`=4, no accept while `busy`.
- Ack never returned, TIMEOUT_CYC=16: `timeout_err` rises 15 cycles after entering REQ, `tx_req` stays 1. Pulse `err_clr` → 0. Later ack completes the transfer normally.
- Assert `rst` in REQ with `tx_ack`=1 held: `tx_req` drops immediately. After release `in_ready`=0 until `tx_ack` goes low plus SYNC_STAGES cycles.
- Preload `xfer_cnt` to 0xFFFF via 65535 instant-ack transfers, then one more: counter wraps to 0x0000.
